// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared constants for the UART transmit and receive paths.
//   UART_DATA_BITS    : payload bits per frame (8N1 framing)
//   UART_CLK_FREQ     : default system clock frequency in Hz
//   UART_BAUD         : default line rate in bits per second
//   uart_state_t      : 2-bit frame state, encoded by the ST_* localparams
//   uart_cnt_width()  : width of a counter that must hold 0..div-1
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_CLK_FREQ   = 50_000_000;
    localparam int UART_BAUD       = 9600;

    typedef logic [1:0] uart_state_t;

    localparam uart_state_t ST_IDLE  = 2'd0;
    localparam uart_state_t ST_START = 2'd1;
    localparam uart_state_t ST_DATA  = 2'd2;
    localparam uart_state_t ST_STOP  = 2'd3;

    // A divider of 1 would give $clog2() == 0; keep at least one bit.
    function automatic int uart_cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// ----------------------------------------------------------------------------
// uart_baud_gen
// Free-running divider producing a one-cycle tick every DIV clocks.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high; counter returns to 0
//   clear : synchronous restart of the count at 0 (realigns the bit grid)
//   tick  : high while the count equals DIV-1, i.e. the last cycle of a period
// ----------------------------------------------------------------------------
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV = UART_CLK_FREQ / UART_BAUD
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int            W    = uart_cnt_width(DIV);
    localparam logic [W-1:0]  LAST = W'(DIV - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// ----------------------------------------------------------------------------
// uart_tx
// 8N1 UART transmitter with a one-byte holding register in front of the
// shift register, so a byte written during a frame follows it with no gap.
//   clk       : system clock, rising edge
//   reset     : synchronous, active-high; aborts any frame, txd back high
//   tx_data   : byte to send, captured only when a write is accepted
//   tx_start  : one-cycle write strobe
//   tx_ready  : holding register empty; a tx_start this cycle is accepted
//   tx_busy   : a frame is on the line (state is not IDLE)
//   txd       : registered serial output, idles high
//   dbg_state : current frame state (ST_IDLE/START/DATA/STOP)
//
// Write handshake: tx_start acts as valid and tx_ready as ready. A write is
// accepted exactly on a rising edge where tx_start=1 and tx_ready=1; tx_data
// is captured on that edge. A tx_start while tx_ready=0 is dropped entirely
// and never retried or queued.
// ----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = UART_CLK_FREQ,
    parameter int BAUD     = UART_BAUD,
    parameter int DIV      = CLK_FREQ / BAUD
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [UART_DATA_BITS-1:0] tx_data,
    input  logic                      tx_start,
    output logic                      tx_ready,
    output logic                      tx_busy,
    output logic                      txd,
    output uart_state_t               dbg_state
);

    localparam int                 BW       = uart_cnt_width(UART_DATA_BITS);
    localparam logic [BW-1:0]      LAST_BIT = BW'(UART_DATA_BITS - 1);

    uart_state_t                r_state;
    uart_state_t                w_state_next;
    logic [UART_DATA_BITS-1:0]  r_hold;
    logic                       r_hold_full;
    logic [UART_DATA_BITS-1:0]  r_shift;
    logic [UART_DATA_BITS-1:0]  w_shift_next;
    logic [BW-1:0]              r_bit_cnt;
    logic                       r_txd;
    logic                       w_txd_next;
    logic                       w_tick;
    logic                       w_accept;
    logic                       w_load;
    logic                       w_clear;

    assign w_accept = tx_start & ~r_hold_full;

    // Holding the divider cleared through IDLE means every frame, including
    // one that follows a stop bit directly, starts its bit grid at count 0.
    assign w_clear  = (r_state == ST_IDLE) | w_load;

    uart_baud_gen #(
        .DIV   (DIV)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .clear (w_clear),
        .tick  (w_tick)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state; w_load marks the holding-to-shift transfer
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_hold_full) begin
                    w_state_next = ST_START;
                    w_load       = 1'b1;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tick && (r_bit_cnt == LAST_BIT)) begin
                    w_state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_hold_full) begin
                        w_state_next = ST_START;
                        w_load       = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        tx_busy   = (r_state != ST_IDLE);
        tx_ready  = ~r_hold_full;
        txd       = r_txd;
        dbg_state = r_state;
    end

    // ------------------------------------------------------------------
    // Datapath: shift register and the line level that goes with the
    // next state. txd is registered from the next-state view so the pin
    // changes on the same edge as the state, never from an input directly.
    // ------------------------------------------------------------------
    always_comb begin
        w_shift_next = r_shift;
        if (w_load) begin
            w_shift_next = r_hold;
        end else if ((r_state == ST_DATA) && w_tick) begin
            w_shift_next = r_shift >> 1;
        end
    end

    always_comb begin
        w_txd_next = 1'b1;
        case (w_state_next)
            ST_IDLE:  w_txd_next = 1'b1;
            ST_START: w_txd_next = 1'b0;
            ST_DATA:  w_txd_next = w_shift_next[0];
            ST_STOP:  w_txd_next = 1'b1;
            default:  w_txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_txd       <= 1'b1;
            r_shift     <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_bit_cnt   <= '0;
        end else begin
            r_txd   <= w_txd_next;
            r_shift <= w_shift_next;

            // Load and accept are exclusive: a load needs the register full,
            // an accept needs it empty.
            if (w_load) begin
                r_hold_full <= 1'b0;
            end else if (w_accept) begin
                r_hold_full <= 1'b1;
            end
            if (w_accept) begin
                r_hold <= tx_data;
            end

            // Counter sits at 0 outside DATA; it wraps from the last bit back
            // to 0 on the same tick that leaves DATA.
            if (r_state != ST_DATA) begin
                r_bit_cnt <= '0;
            end else if (w_tick) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

    // Short bit period so whole frames fit comfortably in the run.
    localparam int CLK_FREQ = 160;
    localparam int BAUD     = 10;
    localparam int DIV      = 16;
    localparam int FRAME    = 10 * DIV;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_ready;
    logic       tx_busy;
    logic       txd;
    logic [1:0] dbg_state;

    uart_tx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_ready  (tx_ready),
        .tx_busy   (tx_busy),
        .txd       (txd),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int  n_checks = 0;
    int  n_pass   = 0;
    bit  chk_on   = 1'b0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // A frame is described only by how many cycles of it remain and which
    // byte it carries; the line level is derived from the position in the
    // frame. One holding slot is modelled as full/empty plus its byte.
    int         m_rem  = 0;
    logic [7:0] m_byte = 8'h00;
    logic       m_full = 1'b0;
    logic [7:0] m_hold = 8'h00;

    function automatic logic model_txd(input int rem, input logic [7:0] b);
        int idx;
        if (rem == 0) return 1'b1;
        idx = (FRAME - rem) / DIV;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return b[idx-1];
    endfunction

    int         rem_n;
    logic       full_n;
    logic [7:0] hold_n;
    logic [7:0] byte_n;
    always @(posedge clk) begin
        if (reset) begin
            m_rem  <= 0;
            m_full <= 1'b0;
        end else begin
            rem_n  = (m_rem > 0) ? m_rem - 1 : 0;
            full_n = m_full;
            hold_n = m_hold;
            byte_n = m_byte;
            // Line free (idle or frame ending now) and a byte waiting: start.
            if ((rem_n == 0) && m_full) begin
                rem_n  = FRAME;
                byte_n = m_hold;
                full_n = 1'b0;
            end
            if (tx_start && !m_full) begin
                full_n = 1'b1;
                hold_n = tx_data;
            end
            m_rem  <= rem_n;
            m_full <= full_n;
            m_hold <= hold_n;
            m_byte <= byte_n;
        end
    end

    // Every cycle: line, busy and ready against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("cycle_model", {29'd0, txd, tx_busy, tx_ready},
                  {29'd0, model_txd(m_rem, m_byte), (m_rem != 0), !m_full});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Strobe for one cycle; returns at the negedge of the following cycle.
    task automatic strobe(input logic [7:0] d);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!(tx_busy === 1'b0 && tx_ready === 1'b1) && k < 4 * FRAME) begin
            tick(1);
            k++;
        end
        check("wait_idle_timeout", {31'd0, (k >= 4 * FRAME)}, 32'd0);
    endtask

    task automatic wait_ready();
        int k = 0;
        while (tx_ready !== 1'b1 && k < 4 * FRAME) begin
            tick(1);
            k++;
        end
        check("wait_ready_timeout", {31'd0, (k >= 4 * FRAME)}, 32'd0);
    endtask

    // Line decoder: finds a start bit, samples at mid-bit.
    task automatic recv_byte(output logic [7:0] b);
        int k = 0;
        b = 8'h00;
        while (txd !== 1'b0 && k < 3 * FRAME) begin
            tick(1);
            k++;
        end
        check("recv_timeout", {31'd0, (k >= 3 * FRAME)}, 32'd0);
        if (k < 3 * FRAME) begin
            tick(DIV / 2);
            check("recv_start_mid", {31'd0, txd}, 32'd0);
            for (int i = 0; i < 8; i++) begin
                tick(DIV);
                b[i] = txd;
            end
            tick(DIV);
            check("recv_stop_mid", {31'd0, txd}, 32'd1);
        end
    endtask

    // ---------------- table-driven single frames ----------------
    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // line level per bit time, [0] = start bit
    } vec_t;

    vec_t vecs[6];

    task automatic send_and_check(input vec_t v);
        int t;
        int target;
        wait_idle();
        tick(2);
        strobe(v.data);                                   // now in N+1
        check("ready_after_accept", {31'd0, tx_ready}, 32'd0);
        tick(1);                                          // now in N+2
        check("start_at_n2", {31'd0, txd}, 32'd0);
        check("ready_at_n2", {31'd0, tx_ready}, 32'd1);
        t = 0;
        for (int k = 0; k < 10; k++) begin
            target = k * DIV + DIV / 2;
            tick(target - t);
            t = target;
            check($sformatf("midbit%0d_%02h", k, v.data), {31'd0, txd}, {31'd0, v.frame[k]});
        end
        tick(FRAME - 1 - t);
        check("busy_last_cycle", {31'd0, tx_busy}, 32'd1);
        tick(1);
        check("busy_fall", {31'd0, tx_busy}, 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0] got;
        longint     t1;
        longint     t2;
        int         lows;
        int         k;

        vecs[0] = '{8'h4A, 10'b1010010100};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'h55, 10'b1010101010};
        vecs[4] = '{8'hA5, 10'b1101001010};
        vecs[5] = '{8'h81, 10'b1100000010};

        // Reset for two cycles.
        tick(2);
        check("reset_txd",   {31'd0, txd},      32'd1);
        check("reset_ready", {31'd0, tx_ready}, 32'd1);
        check("reset_busy",  {31'd0, tx_busy},  32'd0);
        check("reset_state", {30'd0, dbg_state}, 32'd0);
        chk_on = 1'b1;
        reset  = 1'b0;

        lows = 0;
        repeat (10000) begin
            tick(1);
            if (txd !== 1'b1) lows++;
        end
        check("idle_high_10000", lows, 32'd0);

        // Single frames from the table.
        for (int i = 0; i < 6; i++) send_and_check(vecs[i]);

        // Back-to-back: second write as soon as ready returns.
        wait_idle();
        tick(2);
        strobe(8'h01);
        tick(1);
        t1 = cyc;
        check("b2b_first_start", {31'd0, txd}, 32'd0);
        wait_ready();
        strobe(8'hFF);
        tick(int'(9 * DIV + DIV / 2 - (cyc - t1)));
        k = 0;
        while (txd !== 1'b0 && k < 2 * DIV) begin
            tick(1);
            k++;
        end
        t2 = cyc;
        check("b2b_start_spacing", 32'(t2 - t1), FRAME);
        check("b2b_busy", {31'd0, tx_busy}, 32'd1);

        // Writes while full are dropped.
        wait_idle();
        tick(2);
        exp_q.push_back(8'h55);
        strobe(8'h55);
        wait_ready();
        exp_q.push_back(8'hAA);
        strobe(8'hAA);
        check("full_ready_low", {31'd0, tx_ready}, 32'd0);
        strobe(8'h33);
        repeat (2) begin
            recv_byte(got);
            if (exp_q.size() > 0) check("sb_byte", got, exp_q.pop_front());
        end
        lows = 0;
        repeat (2 * FRAME) begin
            tick(1);
            if (txd !== 1'b1) lows++;
        end
        check("dropped_no_frame", lows, 32'd0);
        check("sb_empty", exp_q.size(), 32'd0);

        // Write in the last cycle of STOP with the holding register empty.
        wait_idle();
        tick(2);
        strobe(8'h3C);
        tick(1);
        tick(FRAME - 1);
        check("stop_last_busy",  {31'd0, tx_busy},  32'd1);
        check("stop_last_ready", {31'd0, tx_ready}, 32'd1);
        strobe(8'hC3);
        check("stop_gap_idle", {29'd0, txd, tx_busy, tx_ready}, 32'b100);
        tick(1);
        check("stop_gap_start", {30'd0, txd, tx_busy}, 32'b01);

        // Reset during data bit 3 of 0xA5 (that bit is 0 on the line).
        wait_idle();
        tick(2);
        strobe(8'hA5);
        tick(1);
        tick(4 * DIV + DIV / 2);
        check("mid_bit3_low", {31'd0, txd}, 32'd0);
        reset = 1'b1;
        tick(1);
        check("reset_mid_frame", {29'd0, txd, tx_busy, tx_ready}, 32'b101);
        reset = 1'b0;
        send_and_check(vecs[5]);

        // Randomized writes, some landing while the slot is full; every
        // cycle is compared against the model.
        repeat (50) begin
            tick($urandom_range(0, FRAME + 20));
            strobe(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) strobe(8'($urandom_range(0, 255)));
        end
        wait_idle();
        tick(4);

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
